// File: rtl/fetch_pkg.sv
// Shared types and constants for the instruction fetch stage.
package fetch_pkg;

    localparam int INST_W = 16;
    localparam int PC_W   = 16;

    localparam logic [PC_W-1:0] DEFAULT_RESET_PC = 16'h0000;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        FETCH  = 2'd1,
        HALTED = 2'd2
    } fetch_state_t;

endpackage

// File: rtl/inst_fifo.sv
// Small instruction buffer; each entry carries {pc, inst}.
// Flush empties the buffer at the clock edge and overrides push/pop.
// Head data reads as zero while the buffer is empty.
module inst_fifo #(
    parameter int DEPTH = 2,
    parameter int WIDTH = 32
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     flush,
    input  logic                     push,
    input  logic [WIDTH-1:0]         push_data,
    input  logic                     pop,
    output logic [WIDTH-1:0]         head_data,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     empty,
    output logic                     full
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic             pop_ok;
    logic             push_ok;

    assign empty   = (count == '0);
    assign full    = (count == CW'(DEPTH));
    assign pop_ok  = pop & ~empty;
    // A full buffer may still accept a push when the head leaves the same cycle.
    assign push_ok = push & (~full | pop_ok);

    assign head_data = empty ? '0 : mem[rd_ptr];

    // Pointer and occupancy bookkeeping; reset and flush both empty the buffer.
    always_ff @(posedge clk) begin
        if (!rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else if (flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push_ok) wr_ptr <= wr_ptr + AW'(1);
            if (pop_ok)  rd_ptr <= rd_ptr + AW'(1);
            count <= count + CW'(push_ok) - CW'(pop_ok);
        end
    end

    // Entry storage; contents are only meaningful between write and read pointers.
    always_ff @(posedge clk) begin
        if (rst && !flush && push_ok) begin
            mem[wr_ptr] <= push_data;
        end
    end

endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch stage: owns the PC, issues word reads to a synchronous
// instruction memory (data returns one cycle after the request), buffers the
// returned words and hands them to the controller.
//
// Handshake (inst_valid / inst_ready): inst_valid is asserted whenever the
// buffer holds a word and never depends on inst_ready; inst_out/inst_pc stay
// stable while inst_valid=1 and inst_ready=0; a word is consumed exactly in a
// cycle where inst_valid=1 and inst_ready=1 are both seen at the rising edge.
module fetch_unit
    import fetch_pkg::*;
#(
    parameter int                ADDR_W     = PC_W,
    parameter int                DATA_W     = INST_W,
    parameter logic [ADDR_W-1:0] RESET_PC   = DEFAULT_RESET_PC,
    parameter int                FIFO_DEPTH = 2
) (
    input  logic              clk,
    input  logic              rst,
    output logic              imem_req,
    output logic [ADDR_W-1:0] imem_addr,
    input  logic [DATA_W-1:0] imem_data,
    input  logic              redirect_valid,
    input  logic [ADDR_W-1:0] redirect_pc,
    input  logic              halt,
    output logic              inst_valid,
    input  logic              inst_ready,
    output logic [DATA_W-1:0] inst_out,
    output logic [ADDR_W-1:0] inst_pc,
    output fetch_state_t      state_dbg
);

    localparam int CW      = $clog2(FIFO_DEPTH) + 1;
    localparam int ENTRY_W = ADDR_W + DATA_W;

    fetch_state_t      state;
    fetch_state_t      state_next;
    logic [ADDR_W-1:0] pc;
    logic [ADDR_W-1:0] tag;
    logic              inflight;

    logic [CW-1:0]     count;
    logic              fifo_empty;
    logic              fifo_full;
    logic [ENTRY_W-1:0] head_data;
    logic              pop;
    logic              push;
    logic [CW:0]       occupancy;
    logic              room;

    assign state_dbg  = state;
    assign imem_addr  = pc;
    assign inst_valid = ~fifo_empty;
    assign inst_pc    = head_data[ENTRY_W-1:DATA_W];
    assign inst_out   = head_data[DATA_W-1:0];
    assign pop        = inst_valid & inst_ready;

    // A returning word is dropped only when a redirect makes it stale.
    assign push = inflight & ~redirect_valid;

    // Buffered + outstanding words after this cycle's pop must leave a slot
    // free, so a return can never find the buffer full.
    assign occupancy = {1'b0, count} + (CW+1)'(inflight) - (CW+1)'(pop);
    assign room      = (occupancy < (CW+1)'(FIFO_DEPTH)) & ~(fifo_full & ~pop);

    inst_fifo #(
        .DEPTH (FIFO_DEPTH),
        .WIDTH (ENTRY_W)
    ) u_inst_fifo (
        .clk       (clk),
        .rst       (rst),
        .flush     (redirect_valid),
        .push      (push),
        .push_data ({tag, imem_data}),
        .pop       (pop),
        .head_data (head_data),
        .count     (count),
        .empty     (fifo_empty),
        .full      (fifo_full)
    );

    // FSM state register.
    always_ff @(posedge clk) begin
        if (!rst) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state and request decode; redirect always takes priority over halt.
    always_comb begin
        state_next = state;
        imem_req   = 1'b0;
        case (state)
            IDLE: begin
                state_next = FETCH;
            end
            FETCH: begin
                imem_req = room & ~redirect_valid & ~halt;
                if (!redirect_valid && halt) begin
                    state_next = HALTED;
                end
            end
            HALTED: begin
                if (redirect_valid) begin
                    state_next = FETCH;
                end
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    // PC advances on each issued request (wrapping) or jumps on a redirect.
    always_ff @(posedge clk) begin
        if (!rst) begin
            pc <= RESET_PC;
        end else if (redirect_valid) begin
            pc <= redirect_pc;
        end else if (imem_req) begin
            pc <= pc + ADDR_W'(1);
        end
    end

    // Remember which PC the outstanding read belongs to.
    always_ff @(posedge clk) begin
        if (!rst) begin
            inflight <= 1'b0;
            tag      <= '0;
        end else begin
            inflight <= imem_req;
            if (imem_req) begin
                tag <= pc;
            end
        end
    end

endmodule

// File: tb/tb_fetch_unit.sv
// Self-checking bench for fetch_unit with a queue-based reference model.
module tb_fetch_unit;
    import fetch_pkg::*;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        imem_req;
    logic [15:0] imem_addr;
    logic [15:0] imem_data = 16'h0000;
    logic        redirect_valid = 1'b0;
    logic [15:0] redirect_pc = 16'h0000;
    logic        halt = 1'b0;
    logic        inst_valid;
    logic        inst_ready = 1'b0;
    logic [15:0] inst_out;
    logic [15:0] inst_pc;
    fetch_state_t state_dbg;

    int n_vec = 0;
    int n_err = 0;

    // Reference model: PCs of words the controller will see, in order.
    logic [15:0] exp_q[$];
    logic        m_inflight;
    logic [15:0] m_tag;
    logic [15:0] m_pc;
    int          m_mode;   // 0: just out of reset, 1: fetching, 2: halted

    // Memory responder state.
    logic        prev_req;
    logic [15:0] prev_addr;

    // clock/reset block
    always #5 clk = ~clk;

    fetch_unit dut (
        .clk            (clk),
        .rst            (rst),
        .imem_req       (imem_req),
        .imem_addr      (imem_addr),
        .imem_data      (imem_data),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .halt           (halt),
        .inst_valid     (inst_valid),
        .inst_ready     (inst_ready),
        .inst_out       (inst_out),
        .inst_pc        (inst_pc),
        .state_dbg      (state_dbg)
    );

    function automatic logic [15:0] mem_word(input logic [15:0] a);
        return 16'hA000 + a;
    endfunction

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic model_reset();
        exp_q.delete();
        m_inflight = 1'b0;
        m_tag      = 16'h0000;
        m_pc       = DEFAULT_RESET_PC;
        m_mode     = 0;
    endtask

    // One clock cycle: drive inputs, check outputs, advance the model across the edge.
    task automatic step(input logic r, input logic rv, input logic [15:0] rpc,
                        input logic h, input logic rdy);
        logic        e_valid;
        logic        e_pop;
        logic        e_req;
        logic [15:0] e_pc;
        logic [15:0] e_out;
        int          occ;
        @(negedge clk);
        rst            = r;
        redirect_valid = rv;
        redirect_pc    = rpc;
        halt           = h;
        inst_ready     = rdy;
        imem_data      = prev_req ? mem_word(prev_addr) : 16'($urandom);
        #1;
        e_valid = (exp_q.size() > 0);
        e_pc    = e_valid ? exp_q[0] : 16'h0000;
        e_out   = e_valid ? mem_word(e_pc) : 16'h0000;
        e_pop   = e_valid & rdy;
        occ     = exp_q.size() + int'(m_inflight) - int'(e_pop);
        e_req   = (m_mode == 1) && (occ < 2) && !rv && !h;

        check_val("imem_req",   32'(imem_req),   32'(e_req));
        check_val("imem_addr",  32'(imem_addr),  32'(m_pc));
        check_val("inst_valid", 32'(inst_valid), 32'(e_valid));
        check_val("inst_out",   32'(inst_out),   32'(e_out));
        check_val("inst_pc",    32'(inst_pc),    32'(e_pc));

        prev_req  = imem_req;
        prev_addr = imem_addr;

        if (!r) begin
            model_reset();
        end else begin
            if (e_pop) void'(exp_q.pop_front());
            if (m_inflight && !rv) exp_q.push_back(m_tag);
            if (rv) exp_q.delete();
            m_inflight = e_req;
            if (e_req) m_tag = m_pc;
            if (rv) m_pc = rpc;
            else if (e_req) m_pc = m_pc + 16'h0001;
            case (m_mode)
                0: m_mode = 1;
                1: if (!rv && h) m_mode = 2;
                2: if (rv) m_mode = 1;
                default: m_mode = 0;
            endcase
        end
    endtask

    // driver tasks built on step()
    task automatic run(input int n, input logic rdy);
        for (int i = 0; i < n; i++) step(1'b1, 1'b0, 16'h0000, 1'b0, rdy);
    endtask

    task automatic do_redirect(input logic [15:0] target, input logic rdy);
        step(1'b1, 1'b1, target, 1'b0, rdy);
    endtask

    initial begin
        rst = 1'b0;
        prev_req  = 1'b0;
        prev_addr = 16'h0000;
        repeat (2) @(posedge clk);
        model_reset();

        // Reset held, then release and stream with ready high.
        for (int i = 0; i < 3; i++) step(1'b0, 1'b0, 16'h0000, 1'b0, 1'b1);
        run(12, 1'b1);

        // Backpressure mid-stream.
        run(5, 1'b0);
        run(6, 1'b1);

        // Redirect while buffer is occupied.
        run(2, 1'b0);
        do_redirect(16'h0040, 1'b0);
        run(6, 1'b1);

        // Halt, drain, stay idle, then resume via redirect.
        step(1'b1, 1'b0, 16'h0000, 1'b1, 1'b1);
        run(8, 1'b1);
        do_redirect(16'h0010, 1'b1);
        run(6, 1'b1);

        // PC wrap.
        do_redirect(16'hFFFE, 1'b1);
        run(8, 1'b1);

        // Reset with buffer full and a read outstanding.
        run(1, 1'b1);
        run(2, 1'b0);
        step(1'b0, 1'b0, 16'h0000, 1'b0, 1'b0);
        run(8, 1'b1);

        // Randomized traffic.
        for (int i = 0; i < 600; i++) begin
            logic        r;
            logic        rv;
            logic [15:0] rpc;
            logic        h;
            logic        rdy;
            r   = ($urandom_range(0, 99) != 0);
            rv  = ($urandom_range(0, 15) == 0);
            rpc = ($urandom_range(0, 3) == 0) ? 16'hFFFE : 16'($urandom);
            h   = ($urandom_range(0, 24) == 0);
            rdy = ($urandom_range(0, 3) != 0);
            step(r, rv, rpc, h, rdy);
        end

        // final report
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
